// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, LSB first, one bit per clock
// Operands are latched on START; S/C/V update only when the last bit has been produced.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             bit_s;
  logic             bit_c;

  assign bit_s = op_a[0] ^ op_b[0] ^ carry;
  assign bit_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);

  // Result bits enter from the MSB side so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = bit_s;
    end else begin : g_res_wn
      assign res_next = {bit_s, res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      S     <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
            op_a  <= A;
            op_b  <= MODE ? ~B : B;
            carry <= MODE;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry <= bit_c;
          res   <= res_next;
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            S     <= res_next;
            C     <= bit_c;
            V     <= carry ^ bit_c;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY = (state == ST_RUN) || (state == ST_FIN);
  assign DONE = (state == ST_FIN);

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed and randomised checks of serial_addsub at WIDTH 1, 8, 16, 32
module tb_serial_addsub;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic        START1 = 1'b0, MODE1 = 1'b0;
  logic [0:0]  A1 = '0, B1 = '0, S1;
  logic        BUSY1, DONE1, C1, V1;

  logic        START8 = 1'b0, MODE8 = 1'b0;
  logic [7:0]  A8 = '0, B8 = '0, S8;
  logic        BUSY8, DONE8, C8, V8;

  logic        START16 = 1'b0, MODE16 = 1'b0;
  logic [15:0] A16 = '0, B16 = '0, S16;
  logic        BUSY16, DONE16, C16, V16;

  logic        START32 = 1'b0, MODE32 = 1'b0;
  logic [31:0] A32 = '0, B32 = '0, S32;
  logic        BUSY32, DONE32, C32, V32;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  serial_addsub #(.WIDTH(1)) u_w1 (
    .CLK(CLK), .RST(RST), .START(START1), .MODE(MODE1), .A(A1), .B(B1),
    .BUSY(BUSY1), .DONE(DONE1), .S(S1), .C(C1), .V(V1)
  );
  serial_addsub #(.WIDTH(8)) u_w8 (
    .CLK(CLK), .RST(RST), .START(START8), .MODE(MODE8), .A(A8), .B(B8),
    .BUSY(BUSY8), .DONE(DONE8), .S(S8), .C(C8), .V(V8)
  );
  serial_addsub #(.WIDTH(16)) u_w16 (
    .CLK(CLK), .RST(RST), .START(START16), .MODE(MODE16), .A(A16), .B(B16),
    .BUSY(BUSY16), .DONE(DONE16), .S(S16), .C(C16), .V(V16)
  );
  serial_addsub #(.WIDTH(32)) u_w32 (
    .CLK(CLK), .RST(RST), .START(START32), .MODE(MODE32), .A(A32), .B(B32),
    .BUSY(BUSY32), .DONE(DONE32), .S(S32), .C(C32), .V(V32)
  );

  function automatic logic done_sel(input int w);
    case (w)
      1:       done_sel = DONE1;
      8:       done_sel = DONE8;
      16:      done_sel = DONE16;
      default: done_sel = DONE32;
    endcase
  endfunction

  function automatic logic [33:0] out_sel(input int w);
    case (w)
      1:       out_sel = {C1, V1, 31'd0, S1};
      8:       out_sel = {C8, V8, 24'd0, S8};
      16:      out_sel = {C16, V16, 16'd0, S16};
      default: out_sel = {C32, V32, S32};
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic mode, input logic [31:0] a, input logic [31:0] b);
    case (w)
      1:       begin START1 = st;  MODE1 = mode;  A1 = a[0];     B1 = b[0];     end
      8:       begin START8 = st;  MODE8 = mode;  A8 = a[7:0];   B8 = b[7:0];   end
      16:      begin START16 = st; MODE16 = mode; A16 = a[15:0]; B16 = b[15:0]; end
      default: begin START32 = st; MODE32 = mode; A32 = a;       B32 = b;       end
    endcase
  endtask

  // Independent reference: whole-word arithmetic, overflow from operand/result signs.
  task automatic ref_model(input int w, input logic mode, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] s, output logic c, output logic v);
    longint unsigned mask, beff, sum;
    mask = (64'd1 << w) - 1;
    beff = mode ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
    sum  = ({32'd0, a} & mask) + beff + {63'd0, mode};
    s = 32'(sum & mask);
    c = sum[w];
    v = (a[w-1] == beff[w-1]) && (s[w-1] != a[w-1]);
  endtask

  task automatic run_op(input int w, input logic mode, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_s, input logic exp_c, input logic exp_v, input string name);
    int n;
    logic [33:0] o;
    @(negedge CLK);
    drive(w, 1'b1, mode, a, b);
    @(negedge CLK);
    drive(w, 1'b0, 1'b0, 32'd0, 32'd0);
    n = 0;
    while (!done_sel(w) && n < w + 4) begin
      @(negedge CLK);
      n++;
    end
    o = out_sel(w);
    checks++;
    if (!done_sel(w) || n != w) begin
      failures++;
      $display("FAIL %s latency: done=%0b after %0d cycles, required done=1 after %0d", name, done_sel(w), n, w);
    end
    checks++;
    if (o[31:0] !== exp_s || o[33] !== exp_c || o[32] !== exp_v) begin
      failures++;
      $display("FAIL %s result: S=%h C=%b V=%b, required S=%h C=%b V=%b", name, o[31:0], o[33], o[32], exp_s, exp_c, exp_v);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({BUSY8, DONE8, S8, C8, V8} !== 11'd0 || {BUSY32, DONE32, S32, C32, V32} !== 35'd0) begin
      failures++;
      $display("FAIL reset_state: w8=%h w32=%h, required all zero", {BUSY8, DONE8, S8, C8, V8}, {BUSY32, DONE32, S32, C32, V32});
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic_latency;
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge CLK);
    drive(8, 1'b1, 1'b0, 32'h3C, 32'h0F);
    @(negedge CLK);
    drive(8, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int n = 0; n <= 12; n++) begin
      if (BUSY8) busy_cnt++;
      if (DONE8) begin
        done_cnt++;
        checks++;
        if (n != 8) begin
          failures++;
          $display("FAIL basic_done_pos: DONE at cycle %0d, required 8", n);
        end
      end
      @(negedge CLK);
    end
    checks++;
    if (busy_cnt != 9 || done_cnt != 1) begin
      failures++;
      $display("FAIL basic_busy: busy=%0d done=%0d, required busy=9 done=1", busy_cnt, done_cnt);
    end
    checks++;
    if (S8 !== 8'h4B || C8 !== 1'b0 || V8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: S=%h C=%b V=%b, required S=4b C=0 V=0", S8, C8, V8);
    end
  endtask

  task automatic test_add_sub_edges;
    run_op(8, 1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0, "add_wrap");
    run_op(8, 1'b0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1, "add_ovf");
    run_op(8, 1'b1, 32'h05, 32'h07, 32'hFE, 1'b0, 1'b0, "sub_borrow");
    run_op(8, 1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1, "sub_ovf");
  endtask

  task automatic test_back_to_back;
    int done_cnt;
    done_cnt = 0;
    @(negedge CLK);
    drive(8, 1'b1, 1'b0, 32'h10, 32'h20);
    @(negedge CLK);
    for (int n = 0; n <= 28; n++) begin
      if (n == 0)  drive(8, 1'b1, 1'b1, 32'h01, 32'h02);
      if (n == 12) drive(8, 1'b1, 1'b0, 32'h55, 32'h22);
      if (DONE8) begin
        done_cnt++;
        checks++;
        if (n != 8 && n != 18 && n != 28) begin
          failures++;
          $display("FAIL b2b_done_pos: DONE at cycle %0d, required 8/18/28", n);
        end
        checks++;
        if (n == 8 && {S8, C8, V8} !== {8'h30, 1'b0, 1'b0} ||
            n == 18 && {S8, C8, V8} !== {8'hFF, 1'b0, 1'b0} ||
            n == 28 && {S8, C8, V8} !== {8'h77, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL b2b_result: cycle %0d S=%h C=%b V=%b, required 30/ff/77 with C=0 V=0", n, S8, C8, V8);
        end
      end
      if (n < 28) @(negedge CLK);
    end
    drive(8, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (done_cnt != 3) begin
      failures++;
      $display("FAIL b2b_count: %0d DONE pulses, required 3", done_cnt);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_async_reset;
    int done_cnt;
    done_cnt = 0;
    run_op(8, 1'b0, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0, "pre_reset");
    @(negedge CLK);
    drive(8, 1'b1, 1'b0, 32'h3C, 32'h0F);
    @(negedge CLK);
    drive(8, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({BUSY8, DONE8, S8, C8, V8} !== 11'd0) begin
      failures++;
      $display("FAIL async_reset: BUSY=%b DONE=%b S=%h C=%b V=%b, required all zero", BUSY8, DONE8, S8, C8, V8);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (DONE8 || BUSY8) done_cnt++;
      @(negedge CLK);
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL reset_discard: %0d busy/done cycles after reset, required 0", done_cnt);
    end
    run_op(8, 1'b1, 32'h40, 32'h10, 32'h30, 1'b1, 1'b0, "post_reset");
  endtask

  task automatic test_width1;
    // {mode, a, b} -> {s, c, v}
    logic [2:0] tt [8];
    tt[0] = 3'b000; tt[1] = 3'b100; tt[2] = 3'b100; tt[3] = 3'b011;
    tt[4] = 3'b010; tt[5] = 3'b101; tt[6] = 3'b110; tt[7] = 3'b010;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      logic [2:0] e;
      idx = 3'(i);
      e = tt[i];
      run_op(1, idx[2], {31'd0, idx[1]}, {31'd0, idx[0]}, {31'd0, e[2]}, e[1], e[0], $sformatf("w1_m%0d_a%0d_b%0d", idx[2], idx[1], idx[0]));
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, es;
    logic mode, ec, ev;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      mode = 1'($urandom_range(0, 1));
      ref_model(16, mode, a & 32'hFFFF, b & 32'hFFFF, es, ec, ev);
      run_op(16, mode, a & 32'hFFFF, b & 32'hFFFF, es, ec, ev, $sformatf("rand16_%0d", i));
      ref_model(32, mode, a, b, es, ec, ev);
      run_op(32, mode, a, b, es, ec, ev, $sformatf("rand32_%0d", i));
    end
    ref_model(32, 1'b1, 32'h8000_0000, 32'h0000_0001, es, ec, ev);
    run_op(32, 1'b1, 32'h8000_0000, 32'h0000_0001, es, ec, ev, "w32_sub_ovf");
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_add_sub_edges();
    test_back_to_back();
    test_async_reset();
    test_width1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
